// File: rtl/traffic_pkg.sv
// Shared traffic-controller constants: road count and default jam-detector tuning.
package traffic_pkg;

  localparam int unsigned NUM_ROADS      = 4;
  localparam int unsigned JAM_SAMPLE_DIV = 4;
  localparam int unsigned JAM_CNT_MAX    = 15;
  localparam int unsigned JAM_ON_TH      = 12;
  localparam int unsigned JAM_OFF_TH     = 4;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/jam_road_filter.sv
// Per-road occupancy filter: optional 2-flop synchronizer (JAM_DETECT_SYNC_EN),
// saturating up/down counter advanced on sample ticks, and a hysteresis jam flag.
module jam_road_filter
  import traffic_pkg::*;
#(
  parameter int unsigned CNT_MAX = JAM_CNT_MAX,
  parameter int unsigned ON_TH   = JAM_ON_TH,
  parameter int unsigned OFF_TH  = JAM_OFF_TH
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic occ,
  output logic jam,
  output logic jam_next
);

  localparam int unsigned CNT_W = cnt_width(CNT_MAX);

  logic             occ_s;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

`ifdef JAM_DETECT_SYNC_EN
  logic [1:0] sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= '0;
    else     sync <= {sync[0], occ};
  end

  assign occ_s = sync[1];
`else
  assign occ_s = occ;
`endif

  // Flag is judged on the post-update count so it moves on the crossing edge itself.
  always_comb begin
    cnt_next = cnt;
    jam_next = jam;
    if (tick) begin
      if (occ_s && (cnt < CNT_W'(CNT_MAX)))
        cnt_next = cnt + 1'b1;
      else if (!occ_s && (cnt != '0))
        cnt_next = cnt - 1'b1;

      if (cnt_next >= CNT_W'(ON_TH))
        jam_next = 1'b1;
      else if (cnt_next <= CNT_W'(OFF_TH))
        jam_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      jam <= 1'b0;
    end else begin
      cnt <= cnt_next;
      jam <= jam_next;
    end
  end

endmodule

// File: rtl/jam_detect_unit.sv
// Jam detector front end: shared sample prescaler, four road filters, registered jam_any.
// Define JAM_DETECT_SYNC_EN to synchronize road_occ_* inside each filter.
module jam_detect_unit
  import traffic_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = JAM_SAMPLE_DIV,
  parameter int unsigned CNT_MAX    = JAM_CNT_MAX,
  parameter int unsigned ON_TH      = JAM_ON_TH,
  parameter int unsigned OFF_TH     = JAM_OFF_TH
) (
  input  logic clk,
  input  logic rst,
  input  logic road_occ_0,
  input  logic road_occ_1,
  input  logic road_occ_2,
  input  logic road_occ_3,
  output logic jam_sensor_0,
  output logic jam_sensor_1,
  output logic jam_sensor_2,
  output logic jam_sensor_3,
  output logic jam_any,
  output logic sample_tick
);

  localparam int unsigned PS_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  if ((SAMPLE_DIV < 1) || !(OFF_TH < ON_TH) || !(ON_TH <= CNT_MAX)) begin : g_bad_params
    $error("jam_detect_unit: illegal SAMPLE_DIV/CNT_MAX/ON_TH/OFF_TH combination");
  end

  logic [PS_W-1:0]      ps;
  logic [PS_W-1:0]      ps_next;
  logic [NUM_ROADS-1:0] occ_vec;
  logic [NUM_ROADS-1:0] jam_vec;
  logic [NUM_ROADS-1:0] jam_next_vec;

  assign occ_vec = {road_occ_3, road_occ_2, road_occ_1, road_occ_0};

  always_comb begin
    ps_next = ps + 1'b1;
    if (ps == PS_W'(SAMPLE_DIV - 1)) ps_next = '0;
  end

  // sample_tick is registered from ps_next so it is high exactly while ps == SAMPLE_DIV-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps          <= '0;
      sample_tick <= 1'b0;
      jam_any     <= 1'b0;
    end else begin
      ps          <= ps_next;
      sample_tick <= (ps_next == PS_W'(SAMPLE_DIV - 1));
      jam_any     <= |jam_next_vec;
    end
  end

  for (genvar r = 0; r < NUM_ROADS; r++) begin : g_road
    jam_road_filter #(
      .CNT_MAX (CNT_MAX),
      .ON_TH   (ON_TH),
      .OFF_TH  (OFF_TH)
    ) u_filter (
      .clk      (clk),
      .rst      (rst),
      .tick     (sample_tick),
      .occ      (occ_vec[r]),
      .jam      (jam_vec[r]),
      .jam_next (jam_next_vec[r])
    );
  end

  assign jam_sensor_0 = jam_vec[0];
  assign jam_sensor_1 = jam_vec[1];
  assign jam_sensor_2 = jam_vec[2];
  assign jam_sensor_3 = jam_vec[3];

endmodule

// File: tb/tb_jam_detect_unit.sv
// Directed bench for jam_detect_unit (default build): per-edge scoreboard plus latency checks.
module tb_jam_detect_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic road_occ_0 = 1'b0;
  logic road_occ_1 = 1'b0;
  logic road_occ_2 = 1'b0;
  logic road_occ_3 = 1'b0;
  logic jam_sensor_0, jam_sensor_1, jam_sensor_2, jam_sensor_3;
  logic jam_any, sample_tick;

  jam_detect_unit dut (
    .clk          (clk),
    .rst          (rst),
    .road_occ_0   (road_occ_0),
    .road_occ_1   (road_occ_1),
    .road_occ_2   (road_occ_2),
    .road_occ_3   (road_occ_3),
    .jam_sensor_0 (jam_sensor_0),
    .jam_sensor_1 (jam_sensor_1),
    .jam_sensor_2 (jam_sensor_2),
    .jam_sensor_3 (jam_sensor_3),
    .jam_any      (jam_any),
    .sample_tick  (sample_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] jam;
    logic       any;
    logic       tick;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model state (defaults: SAMPLE_DIV=4, CNT_MAX=15, ON=12, OFF=4)
  int         m_ps = 0;
  logic       m_tick = 1'b0;
  int         m_cnt[4] = '{0, 0, 0, 0};
  logic [3:0] m_jam = '0;
  logic       m_any = 1'b0;
  int         ec = 0;

  function automatic logic [5:0] observed();
    return {jam_sensor_3, jam_sensor_2, jam_sensor_1, jam_sensor_0, jam_any, sample_tick};
  endfunction

  task automatic model_reset();
    m_ps = 0; m_tick = 1'b0; m_jam = '0; m_any = 1'b0;
    for (int r = 0; r < 4; r++) m_cnt[r] = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [3:0] occ);
    exp_t e;
    logic [5:0] obs;
    {road_occ_3, road_occ_2, road_occ_1, road_occ_0} = occ;
    if (rst) begin
      model_reset();
    end else begin
      if (m_tick) begin
        for (int r = 0; r < 4; r++) begin
          if (occ[r] && m_cnt[r] < 15) m_cnt[r]++;
          else if (!occ[r] && m_cnt[r] > 0) m_cnt[r]--;
          if (m_cnt[r] >= 12) m_jam[r] = 1'b1;
          else if (m_cnt[r] <= 4) m_jam[r] = 1'b0;
        end
      end
      m_any  = |m_jam;
      m_ps   = (m_ps == 3) ? 0 : m_ps + 1;
      m_tick = (m_ps == 3);
      ec++;
    end
    q.push_back('{jam: m_jam, any: m_any, tick: m_tick});
    @(posedge clk);
    #1;
    e   = q.pop_front();
    obs = observed();
    tests++;
    assert (obs === e) else begin
      fails++;
      $error("FAIL step ec=%0d observed=%b expected=%b", ec, obs, e);
    end
  endtask

  initial begin
    int   rise_at;
    int   fall_at;
    logic occ1;
    logic ever1;

    // 1: held in reset with all detectors occupied
    road_occ_0 = 1'b1; road_occ_1 = 1'b1; road_occ_2 = 1'b1; road_occ_3 = 1'b1;
    #1;
    check("reset_initial", {26'd0, observed()}, 32'd0);
    for (int i = 0; i < 8; i++) step(4'b1111);
    check("reset_hold", {26'd0, observed()}, 32'd0);

    // 2: release, road 0 occupied
    rst = 1'b0;
    ec = 0;
    rise_at = -1;
    for (int i = 0; i < 60; i++) begin
      step(4'b0001);
      if (rise_at < 0 && jam_sensor_0 === 1'b1) rise_at = ec;
    end
    check("road0_rise_edge", rise_at, 48);
    check("road0_any_after_rise", {31'd0, jam_any}, 32'd1);

    // 3: counter saturated at 15, now empty ticks until clear
    fall_at = -1;
    for (int i = 0; i < 60; i++) begin
      step(4'b0000);
      if (fall_at < 0 && jam_sensor_0 === 1'b0) fall_at = ec - 60;
    end
    check("road0_fall_edges", fall_at, 44);
    check("road0_any_after_fall", {31'd0, jam_any}, 32'd0);

    // 4: road 1 chatters every tick; ec is tick-aligned here (120)
    occ1 = 1'b1;
    ever1 = 1'b0;
    for (int i = 0; i < 400; i++) begin
      step({2'b00, occ1, 1'b0});
      if (jam_sensor_1 === 1'b1) ever1 = 1'b1;
      if (ec % 4 == 0) occ1 = ~occ1;
    end
    check("road1_chatter_never_jams", {31'd0, ever1}, 32'd0);

    // 5: road 2 to jam, then asynchronous reset pulse between edges
    rise_at = -1;
    for (int i = 0; i < 50; i++) begin
      step(4'b0100);
      if (rise_at < 0 && jam_sensor_2 === 1'b1) rise_at = ec - 520;
    end
    check("road2_rise_edges", rise_at, 48);
    check("road2_jam_before_rst", {31'd0, jam_sensor_2}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_jam2", {31'd0, jam_sensor_2}, 32'd0);
    check("async_rst_any", {31'd0, jam_any}, 32'd0);
    check("async_rst_tick", {31'd0, sample_tick}, 32'd0);
    #1 rst = 1'b0;
    model_reset();
    ec = 0;
    rise_at = -1;
    for (int i = 0; i < 52; i++) begin
      step(4'b0100);
      if (rise_at < 0 && jam_sensor_2 === 1'b1) rise_at = ec;
    end
    check("road2_rerise_edge", rise_at, 48);
    check("road2_others_quiet", {29'd0, jam_sensor_3, jam_sensor_1, jam_sensor_0}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
